// File: rtl/avalon_mem_slave.sv
// Avalon-MM word RAM responder with programmable waitrequest stalls and a sticky protocol_error flag.
// Optional feature: define RANDOM_WAIT_EN to add 0..3 LFSR-chosen extra stall cycles per transfer.
module avalon_mem_slave #(
  parameter int    ADDR_WIDTH    = 12,
  parameter int    WAIT_CYCLES   = 2,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        protocol_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(WAIT_CYCLES + 4);

  typedef enum logic {IDLE, STALL} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next, stall_len;
  logic [31:0]             lat_addr, lat_wdata;
  logic [3:0]              lat_be;
  logic                    lat_read, lat_write;
  logic                    req, start, accept, abort, mismatch;
  logic                    zero_rd, show_fetch;
  logic [31:0]             mem [DEPTH];
  logic [31:0]             fetch, rdata_q;
  logic [ADDR_WIDTH-1:0]   cur_idx;
  logic [31:0]             cur_wdata;
  logic [3:0]              cur_be;
  logic                    cur_write;

`ifdef RANDOM_WAIT_EN
  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1; the pre-step value sizes the transfer that is starting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     lfsr <= 8'hA5;
    else if (start) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall_len = CNT_W'(WAIT_CYCLES) + CNT_W'(lfsr[1:0]);
`else
  assign stall_len = CNT_W'(WAIT_CYCLES);
`endif

  assign req = read | write;

  // In IDLE the live bus is the transfer; in STALL the copy latched at start is.
  assign cur_write = (state == IDLE) ? write      : lat_write;
  assign cur_wdata = (state == IDLE) ? writedata  : lat_wdata;
  assign cur_be    = (state == IDLE) ? byteenable : lat_be;
  assign cur_idx   = (state == IDLE) ? address[ADDR_WIDTH+1:2] : lat_addr[ADDR_WIDTH+1:2];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next  = state;
    cnt_next    = cnt;
    waitrequest = 1'b0;
    start       = 1'b0;
    accept      = 1'b0;
    abort       = 1'b0;
    mismatch    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          start = 1'b1;
          if (stall_len == '0) begin
            accept = 1'b1;
          end else begin
            waitrequest = 1'b1;
            cnt_next    = stall_len - CNT_W'(1);
            state_next  = STALL;
          end
        end
      end
      STALL: begin
        waitrequest = (cnt != '0);
        if (!req) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          mismatch = (address != lat_addr) || (writedata != lat_wdata) || (byteenable != lat_be);
          if (cnt == '0) begin
            accept     = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (!reset) waitrequest = 1'b1;
  end

  // Prefetched word is shown in a stalled read's acceptance cycle or the cycle after a zero-wait read.
  assign show_fetch = zero_rd || (state == STALL && cnt == '0 && lat_read && !lat_write && req);
  assign readdata   = show_fetch ? fetch : rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      rdata_q        <= '0;
      zero_rd        <= 1'b0;
      protocol_error <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      lat_be         <= '0;
      lat_read       <= 1'b0;
      lat_write      <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      rdata_q <= readdata;
      zero_rd <= accept && (state == IDLE) && read && !write;
      if (start) begin
        lat_addr  <= address;
        lat_wdata <= writedata;
        lat_be    <= byteenable;
        lat_read  <= read;
        lat_write <= write;
      end
      if ((start && read && write) || abort || mismatch) protocol_error <= 1'b1;
    end
  end

  // NOTE: the RAM array and its read register are deliberately left out of reset; contents survive it.
  always_ff @(posedge clk) begin
    fetch <= mem[cur_idx];
    if (accept && cur_write) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_avalon_mem_slave.sv
// Bench for avalon_mem_slave: a WAIT_CYCLES=2 instance and a zero-wait instance (one wait under RANDOM_WAIT_EN),
// driven from a vector table plus hand sequences; read data is checked through a scoreboard queue.
module tb_avalon_mem_slave;

  localparam int WAIT_A = 2;
`ifdef RANDOM_WAIT_EN
  localparam int WAIT_B = 1;
`else
  localparam int WAIT_B = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       rd, wr, waitreq, perr;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0][3:0]  be;

  int          tests  = 0;
  int          failed = 0;
  logic [31:0] sb [$];
  logic [31:0] last_rd [2];
  logic [7:0]  lfsr_m [2];

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [19];

  always #5 clk = ~clk;

  avalon_mem_slave #(.ADDR_WIDTH(12), .WAIT_CYCLES(WAIT_A)) u_dut_a (
    .clk(clk), .reset(reset), .address(addr[0]), .read(rd[0]), .write(wr[0]),
    .writedata(wdata[0]), .byteenable(be[0]), .waitrequest(waitreq[0]),
    .readdata(rdata[0]), .protocol_error(perr[0])
  );

  avalon_mem_slave #(.ADDR_WIDTH(12), .WAIT_CYCLES(WAIT_B)) u_dut_b (
    .clk(clk), .reset(reset), .address(addr[1]), .read(rd[1]), .write(wr[1]),
    .writedata(wdata[1]), .byteenable(be[1]), .waitrequest(waitreq[1]),
    .readdata(rdata[1]), .protocol_error(perr[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_len(input int d);
`ifdef RANDOM_WAIT_EN
    return ((d == 0) ? WAIT_A : WAIT_B) + int'(lfsr_m[d][1:0]);
`else
    return (d == 0) ? WAIT_A : WAIT_B;
`endif
  endfunction

  task automatic lfsr_step(input int d);
    lfsr_m[d] = {lfsr_m[d][6:0], lfsr_m[d][7] ^ lfsr_m[d][5] ^ lfsr_m[d][4] ^ lfsr_m[d][3]};
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      lfsr_m[d]  = 8'hA5;
      last_rd[d] = '0;
    end
  endtask

  // mode 0: clean transfer; 1: change address/data/lanes after first stall cycle; 2: drop request there.
  task automatic xfer(input int d, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] b, input logic [31:0] exp_rd,
                      input int mode, input string tag);
    int          n, elen;
    logic        hi;
    logic [31:0] exp_out;
    elen = exp_len(d);
    lfsr_step(d);
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    if (r && !w) sb.push_back(exp_rd);
    n = 0;
    forever begin
      @(negedge clk);
      hi = waitreq[d];
      if (!hi) break;
      n++;
      if (n > 40) begin
        check({tag, " timeout"}, 32'(n), 32'(elen));
        rd[d] = 1'b0; wr[d] = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      if (n == 1 && mode == 1) begin
        addr[d] = a + 32'h4; wdata[d] = ~wd; be[d] = ~b;
      end
      if (n == 1 && mode == 2) begin
        rd[d] = 1'b0; wr[d] = 1'b0;
        @(posedge clk); #1;
        return;
      end
    end
    check({tag, " stall"}, 32'(n), 32'(elen));
    if (r && !w) begin
      exp_out    = sb.pop_front();
      last_rd[d] = exp_out;
    end else begin
      exp_out = last_rd[d];
    end
    if (elen > 0) check({tag, " rdata"}, rdata[d], exp_out);
    @(posedge clk); #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
    if (elen == 0) begin
      @(negedge clk);
      check({tag, " rdata"}, rdata[d], exp_out);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst perr", 32'(perr[0]), 32'd0);
    check("rst rdata", rdata[0], 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    rd = '0; wr = '0; addr = '0; wdata = '0; be = '0;
    model_reset();

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'h11BB_33DD};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0023, 32'h0,         4'hF, 32'h11BB_33DD};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_4010, 32'h0000_00FF, 4'h1, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEFF};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'h0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEFF};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0044, 32'h0102_0304, 4'hF, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 4'hC, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         4'hF, 32'hCAFE_0304};
    vecs[13] = '{1'b0, 1'b1, 32'h0000_3FFC, 32'h5A5A_5A5A, 4'hF, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 32'h5A5A_5A5A};
    vecs[15] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_4040, 4'hF, 32'h0};
    vecs[16] = '{1'b0, 1'b1, 32'h0000_0050, 32'h5050_5050, 4'hF, 32'h0};
    vecs[17] = '{1'b0, 1'b1, 32'h0000_0060, 32'h6060_6060, 4'hF, 32'h0};
    vecs[18] = '{1'b0, 1'b1, 32'h0000_0064, 32'h6464_6464, 4'hF, 32'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset waitreq", 32'(waitreq[d]), 32'd1);
      check("reset rdata", rdata[d], 32'd0);
      check("reset perr", 32'(perr[d]), 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle waitreq a", 32'(waitreq[0]), 32'd0);
    check("idle waitreq b", 32'(waitreq[1]), 32'd0);
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 19; i++) begin
        xfer(d, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].b, vecs[i].exp, 0,
             $sformatf("vec%0d dut%0d", i, d));
      end
      check("table perr", 32'(perr[d]), 32'd0);
    end

`ifdef RANDOM_WAIT_EN
    for (int i = 0; i < 16; i++)
      xfer(1, 1'b0, 1'b1, 32'(i * 4 + 32'h100), 32'h0101_0101 * 32'(i + 1), 4'hF, 32'h0, 0, "rnd wr");
    for (int i = 0; i < 16; i++)
      xfer(1, 1'b1, 1'b0, 32'(i * 4 + 32'h100), 32'h0, 4'hF, 32'h0101_0101 * 32'(i + 1), 0, "rnd rd");
`else
    for (int i = 0; i < 3; i++)
      xfer(1, 1'b0, 1'b1, 32'(i * 4), 32'(i + 1), 4'hF, 32'h0, 0, "b2b preload");
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        rd[1] = 1'b1; addr[1] = 32'(i * 4); sb.push_back(32'(i + 1));
      end else begin
        rd[1] = 1'b0;
      end
      @(negedge clk);
      if (i < 3) check("b2b waitreq", 32'(waitreq[1]), 32'd0);
      if (i > 0) check("b2b rdata", rdata[1], sb.pop_front());
      @(posedge clk); #1;
    end
    last_rd[1] = 32'd3;
`endif

    // read and write together: write lands, readdata holds, flag is sticky
    xfer(0, 1'b1, 1'b1, 32'h30, 32'h0BAD_F00D, 4'hF, 32'h0, 0, "rw");
    check("rw perr", 32'(perr[0]), 32'd1);
    xfer(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 32'h0BAD_F00D, 0, "rw readback");
    check("rw perr sticky", 32'(perr[0]), 32'd1);

    // reset during the stall of a write
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'h7777_7777; be[0] = 4'hF;
    @(negedge clk);
    check("rst-stall waitreq", 32'(waitreq[0]), 32'd1);
    reset = 1'b0;
    #1;
    check("rst-stall rdata", rdata[0], 32'd0);
    check("rst-stall perr", 32'(perr[0]), 32'd0);
    @(posedge clk); #1;
    wr[0] = 1'b0;
    @(negedge clk);
    check("rst-held waitreq", 32'(waitreq[0]), 32'd1);
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    xfer(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 32'h0000_4040, 0, "rst-stall readback");

    // inputs changed mid-stall: latched values win
    xfer(0, 1'b0, 1'b1, 32'h60, 32'hA1A1_A1A1, 4'hF, 32'h0, 1, "chg");
    check("chg perr", 32'(perr[0]), 32'd1);
    xfer(0, 1'b1, 1'b0, 32'h60, 32'h0, 4'hF, 32'hA1A1_A1A1, 0, "chg rd60");
    xfer(0, 1'b1, 1'b0, 32'h64, 32'h0, 4'hF, 32'h6464_6464, 0, "chg rd64");

    // request dropped mid-stall: no write
    do_reset();
    xfer(0, 1'b0, 1'b1, 32'h50, 32'hDEAD_0050, 4'hF, 32'h0, 2, "drop");
    check("drop perr", 32'(perr[0]), 32'd1);
    xfer(0, 1'b1, 1'b0, 32'h50, 32'h0, 4'hF, 32'h5050_5050, 0, "drop readback");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
